// File: rtl/rx_recovery_pkg.sv
// Shared types and header constants for the 66b receive-recovery path
// (header seeker, block aligner, decoder).
package rx_recovery_pkg;

   localparam logic [1:0] c_DATA_HEADER = 2'b01;
   localparam logic [1:0] c_CMD_HEADER  = 2'b10;

   typedef enum logic [1:0] {
      SEARCH  = 2'd0,
      CONFIRM = 2'd1,
      LOCKED  = 2'd2
   } aligner_state_t;

   typedef logic [65:0] block66_t;

   function automatic logic hdr_is_valid(input logic [1:0] hdr);
      return (hdr == c_DATA_HEADER) || (hdr == c_CMD_HEADER);
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/aligner_lock_fsm.sv
// 66b block lock state machine: SEARCH -> CONFIRM -> LOCKED with
// windowed bad-header monitoring; advances only on hdr_strobe cycles.
module aligner_lock_fsm
   import rx_recovery_pkg::*;
#(
   parameter int GOOD_CNT = 32,
   parameter int BAD_MAX  = 16,
   parameter int WIN_LEN  = 64
) (
   input  logic           clk_i,
   input  logic           rst_i,
   input  logic           hdr_strobe,
   input  logic           hdr_valid,
   output aligner_state_t state,
   output logic           locked,
   output logic           err_pulse
);

   localparam int CW = $clog2(max_int(GOOD_CNT, WIN_LEN) + 1);

   aligner_state_t state_r, state_nxt_s;
   logic [CW-1:0]  good_r, bad_r, win_r;
   logic [CW-1:0]  good_nxt_s, bad_nxt_s, win_nxt_s;
   logic [CW-1:0]  good_inc_s, bad_inc_s, win_inc_s;
   logic           locked_r, err_r;
   logic           locked_nxt_s, err_nxt_s;

   // state, counter and registered-output update
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r  <= SEARCH;
         good_r   <= {CW{1'b0}};
         bad_r    <= {CW{1'b0}};
         win_r    <= {CW{1'b0}};
         locked_r <= 1'b0;
         err_r    <= 1'b0;
      end else begin
         state_r  <= state_nxt_s;
         good_r   <= good_nxt_s;
         bad_r    <= bad_nxt_s;
         win_r    <= win_nxt_s;
         locked_r <= locked_nxt_s;
         err_r    <= err_nxt_s;
      end
   end

   // next-state and counter evaluation
   always_comb begin
      state_nxt_s = state_r;
      good_nxt_s  = good_r;
      bad_nxt_s   = bad_r;
      win_nxt_s   = win_r;
      good_inc_s  = good_r + CW'(1);
      win_inc_s   = win_r + CW'(1);
      if (hdr_valid) begin
         bad_inc_s = bad_r;
      end else begin
         bad_inc_s = bad_r + CW'(1);
      end
      if (hdr_strobe) begin
         case (state_r)
            SEARCH: begin
               if (hdr_valid) begin
                  state_nxt_s = CONFIRM;
                  good_nxt_s  = CW'(1);
               end else begin
                  state_nxt_s = SEARCH;
               end
            end
            CONFIRM: begin
               if (!hdr_valid) begin
                  state_nxt_s = SEARCH;
                  good_nxt_s  = {CW{1'b0}};
               end else if (good_inc_s == CW'(GOOD_CNT)) begin
                  state_nxt_s = LOCKED;
                  good_nxt_s  = {CW{1'b0}};
                  win_nxt_s   = {CW{1'b0}};
                  bad_nxt_s   = {CW{1'b0}};
               end else begin
                  good_nxt_s  = good_inc_s;
               end
            end
            LOCKED: begin
               // unlock has priority over a coincident window end
               if (bad_inc_s == CW'(BAD_MAX)) begin
                  state_nxt_s = SEARCH;
                  good_nxt_s  = {CW{1'b0}};
                  win_nxt_s   = {CW{1'b0}};
                  bad_nxt_s   = {CW{1'b0}};
               end else if (win_inc_s == CW'(WIN_LEN)) begin
                  win_nxt_s   = {CW{1'b0}};
                  bad_nxt_s   = {CW{1'b0}};
               end else begin
                  win_nxt_s   = win_inc_s;
                  bad_nxt_s   = bad_inc_s;
               end
            end
            default: begin
               state_nxt_s = SEARCH;
               good_nxt_s  = {CW{1'b0}};
               win_nxt_s   = {CW{1'b0}};
               bad_nxt_s   = {CW{1'b0}};
            end
         endcase
      end else begin
         state_nxt_s = state_r;
      end
   end

   // values captured into the registered outputs
   always_comb begin
      locked_nxt_s = (state_nxt_s == LOCKED);
      if (hdr_strobe && (state_r == LOCKED) && !hdr_valid) begin
         err_nxt_s = 1'b1;
      end else begin
         err_nxt_s = 1'b0;
      end
   end

   assign state     = state_r;
   assign locked    = locked_r;
   assign err_pulse = err_r;

endmodule

// File: rtl/block_aligner.sv
// Extracts aligned 66b blocks from the gearbox buffer and maintains block lock.
// Optional statistics counters are built when BLOCK_ALIGNER_STATS_EN is defined.
module block_aligner
   import rx_recovery_pkg::*;
#(
   parameter int GOOD_CNT = 32,
   parameter int BAD_MAX  = 16,
   parameter int WIN_LEN  = 64
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic [193:0] gbox_buffer,
   input  logic [5:0]   gbox_cnt,
   input  logic         buffer_dv,
   input  logic [6:0]   block_offset,
   output logic [65:0]  block_o,
   output logic         block_dv_o,
   output logic         block_locked_o,
   output logic         header_err_o
`ifdef BLOCK_ALIGNER_STATS_EN
   ,
   output logic [15:0]  lock_loss_cnt_o,
   output logic [15:0]  header_err_cnt_o
`endif
);

   aligner_state_t state_s;
   logic           locked_s;
   logic           err_s;
   logic [6:0]     lock_offset_r;
   logic [6:0]     off_s;
   logic [7:0]     lo_s;
   block66_t       cand_s;
   logic           hdr_valid_s;
   block66_t       block_r;
   logic           block_dv_r;

   // candidate extraction; lo_s is the lowest buffer bit of the 66b window
   always_comb begin
      if (state_s == SEARCH) begin
         off_s = block_offset;
      end else begin
         off_s = lock_offset_r;
      end
      lo_s        = 8'd128 - {2'b00, gbox_cnt} - {1'b0, off_s};
      cand_s      = block66_t'(gbox_buffer >> lo_s);
      hdr_valid_s = hdr_is_valid(cand_s[65:64]);
   end

   aligner_lock_fsm #(
      .GOOD_CNT (GOOD_CNT),
      .BAD_MAX  (BAD_MAX),
      .WIN_LEN  (WIN_LEN)
   ) u_lock_fsm (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .hdr_strobe (buffer_dv),
      .hdr_valid  (hdr_valid_s),
      .state      (state_s),
      .locked     (locked_s),
      .err_pulse  (err_s)
   );

   // offset latch and block output register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         lock_offset_r <= 7'd0;
         block_r       <= 66'd0;
         block_dv_r    <= 1'b0;
      end else begin
         if (buffer_dv && (state_s == SEARCH) && hdr_valid_s) begin
            lock_offset_r <= block_offset;
         end
         if (buffer_dv && (state_s == LOCKED)) begin
            block_r    <= cand_s;
            block_dv_r <= 1'b1;
         end else begin
            block_dv_r <= 1'b0;
         end
      end
   end

   assign block_o        = block_r;
   assign block_dv_o     = block_dv_r;
   assign block_locked_o = locked_s;
   assign header_err_o   = err_s;

`ifdef BLOCK_ALIGNER_STATS_EN
   logic        was_locked_r;
   logic [15:0] lock_loss_cnt_r;
   logic [15:0] header_err_cnt_r;

   // saturating lock-loss and header-error counters
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         was_locked_r     <= 1'b0;
         lock_loss_cnt_r  <= 16'd0;
         header_err_cnt_r <= 16'd0;
      end else begin
         was_locked_r <= (state_s == LOCKED);
         if (was_locked_r && (state_s == SEARCH) && (lock_loss_cnt_r != 16'hFFFF)) begin
            lock_loss_cnt_r <= lock_loss_cnt_r + 16'd1;
         end
         if (err_s && (header_err_cnt_r != 16'hFFFF)) begin
            header_err_cnt_r <= header_err_cnt_r + 16'd1;
         end
      end
   end

   assign lock_loss_cnt_o  = lock_loss_cnt_r;
   assign header_err_cnt_o = header_err_cnt_r;
`endif

endmodule

// File: doc/block_aligner.md
Name: block_aligner

Overview:
- Stage directly downstream of the 66b header seeker.
- Consumes the seeker's block_offset and the shared gearbox buffer.
- Confirms and maintains 66b block lock with a lock/unlock state machine.
- Extracts aligned 66-bit blocks (2-bit header + 64-bit payload) with a data-valid strobe for the decoder.

Parameters:
- GOOD_CNT, 32: consecutive valid headers at a fixed offset required to declare lock.
- BAD_MAX, 16: invalid headers within one monitoring window that force loss of lock.
- WIN_LEN, 64: blocks per monitoring window while locked.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous active-high reset.
- gbox_buffer  in  194  complete gearbox buffer.
- gbox_cnt  in  6  buffer view window index, 0..63.
- buffer_dv  in  1  buffer data valid; one block candidate per pulse.
- block_offset  in  7  seeker's candidate header offset, 0..65.
- block_o  out  66  aligned block; [65:64] header, [63:0] payload.
- block_dv_o  out  1  block_o valid; asserted only while locked.
- block_locked_o  out  1  block lock status.
- header_err_o  out  1  one-cycle pulse per invalid header while locked.

Behaviour:
- One clock. Reset is synchronous and active-high: clock port clk_i, reset port rst_i.
- Reset values: block_o=0, block_dv_o=0, block_locked_o=0, header_err_o=0, state=SEARCH, all counters=0, lock_offset=0.
- Extraction:
  - On each buffer_dv cycle, cand = gbox_buffer[193 - gbox_cnt - off -: 66].
  - off = block_offset in SEARCH; off = lock_offset otherwise.
  - Index arithmetic is 8-bit unsigned. The lowest bit reached is 193-63-65-65 = 0, so no underflow is legal.
  - Inputs with gbox_cnt>63 or offset>65 are out of contract; behaviour is unspecified.
- Header valid iff cand[65:64] == 2'b01 (data) or 2'b10 (cmd).
- Latency: block_o, block_dv_o and header_err_o register on the clock edge ending the buffer_dv cycle (1-cycle latency). block_dv_o is low in every cycle not following a buffer_dv.
- State machine (evaluated only on buffer_dv cycles; idle cycles hold all state):
  - SEARCH: valid header → latch lock_offset=block_offset, good_cnt=1, go to CONFIRM. Invalid → stay.
  - CONFIRM:
    - Valid header → good_cnt+1.
    - When good_cnt reaches GOOD_CNT (the counter's own increment reaches GOOD_CNT on this valid) → LOCKED, clear win_cnt and bad_cnt.
    - Invalid header → SEARCH, good_cnt=0.
    - block_offset changes are ignored in CONFIRM and LOCKED.
  - LOCKED:
    - block_locked_o=1; every block drives block_dv_o=1, including invalid ones.
    - Invalid header → header_err_o pulse, bad_cnt+1.
    - win_cnt increments per block.
    - bad_cnt reaching BAD_MAX → SEARCH on that same edge; block_locked_o and block_dv_o drop from the next cycle; counters cleared.
    - Otherwise, win_cnt reaching WIN_LEN → clear win_cnt and bad_cnt.
    - Simultaneous BAD_MAX and window end → BAD_MAX wins (unlock).
- block_locked_o is registered and equals (state==LOCKED).
- block_o holds its last value when block_dv_o=0.
- Reset mid-operation: immediate return to SEARCH on the next edge; any in-flight block is discarded (block_dv_o=0).
- Counter widths: $clog2(max(GOOD_CNT, WIN_LEN)+1) bits; they never wrap.

Optional Feature:
- Macro: BLOCK_ALIGNER_STATS_EN.
- Defined: adds out ports lock_loss_cnt_o[15:0] and header_err_cnt_o[15:0].
  - Both are saturating at 16'hFFFF and reset to 0.
  - lock_loss_cnt_o increments on each LOCKED→SEARCH transition.
  - header_err_cnt_o increments with each header_err_o pulse.
- Undefined: ports and counters absent. Remaining behaviour is identical.

Decomposition:
- Package rx_recovery_pkg holds:
  - c_DATA_HEADER = 2'b01 and c_CMD_HEADER = 2'b10.
  - State enum aligner_state_t {SEARCH, CONFIRM, LOCKED}.
  - Typedef block66_t = logic [65:0].
- One natural sub-module, aligner_lock_fsm: takes hdr_valid and hdr_strobe; outputs the state, locked and err pulse. The top keeps extraction and the stats counters.

Test Plan:
- Reset, then 40 buffer_dv pulses with valid headers at offset 5 → block_locked_o rises on the edge after the 32nd pulse; block_dv_o first asserts with block 33; block_o matches the golden block.
- Locked; block_offset input changes 5→20 → extraction stays at offset 5; blocks unchanged; lock held.
- CONFIRM after 10 good; one header 2'b11 → back to SEARCH; no block_dv_o; the next valid header relatches the offset.
- Locked; 16 invalid headers within 64 blocks → 16 header_err_o pulses; block_locked_o falls the cycle after the 16th. 15 invalid per window, repeated for 3 windows → lock held.
- Locked at gbox_cnt=63, offset=65 → block_o = gbox_buffer[65:0] with no out-of-range access. Assert rst_i mid-stream → all outputs 0 on the next cycle.
- BLOCK_ALIGNER_STATS_EN defined; lock, unlock twice → lock_loss_cnt_o=2 and header_err_cnt_o=32. Force 70000 errors → header_err_cnt_o saturates at 16'hFFFF.
